// File: rtl/rr_grant_mux.sv
// rr_grant_mux: steers the arbiter-granted requestor beat into a 2-entry tagged output buffer.
// Optional packet locking is enabled by defining PKT_LOCK_EN.
module rr_grant_mux #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    grant,
  input  logic [3:0]    req_vld,
  input  logic [4*DW-1:0] req_data,
  input  logic [3:0]    req_last,
  output logic [3:0]    req_rdy,
  output logic          out_vld,
  output logic [DW-1:0] out_data,
  output logic [1:0]    out_src,
  output logic          out_last,
  input  logic          out_rdy
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  logic          rdy_en;
  logic [1:0]    cnt;
  logic          wptr;
  logic          rptr;
  logic [DW-1:0] buf_data [2];
  logic [1:0]    buf_src  [2];
  logic          buf_last [2];

  logic [1:0]    sel;
  logic [DW-1:0] sel_data;
  logic          wr_last;
  logic          can_push;
  logic          push;
  logic          pop;

`ifdef PKT_LOCK_EN
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t     state;
  logic [1:0] lock_src;

  assign sel     = (state == LOCKED) ? lock_src : grant;
  assign wr_last = req_last[sel];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      lock_src <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (push && !wr_last) begin
            lock_src <= sel;
            state    <= LOCKED;
          end
        end
        LOCKED: begin
          if (push && wr_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  logic unused_last;

  assign sel         = grant;
  assign wr_last     = 1'b0;
  assign unused_last = ^req_last;
`endif

  // rdy_en holds req_rdy low during reset and for the first cycle after release
  assign can_push = rdy_en && (cnt != FULL);
  assign sel_data = req_data[32'(sel)*DW +: DW];
  assign push     = req_vld[sel] && can_push;
  assign out_vld  = (cnt != '0);
  assign pop      = out_vld && out_rdy;

  always_comb begin
    req_rdy      = '0;
    req_rdy[sel] = can_push;
  end

  assign out_data = buf_data[rptr];
  assign out_src  = buf_src[rptr];
  assign out_last = buf_last[rptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_en <= 1'b0;
      cnt    <= '0;
      wptr   <= 1'b0;
      rptr   <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        buf_data[i] <= '0;
        buf_src[i]  <= '0;
        buf_last[i] <= 1'b0;
      end
    end else begin
      rdy_en <= 1'b1;
      if (push) begin
        buf_data[wptr] <= sel_data;
        buf_src[wptr]  <= sel;
        buf_last[wptr] <= wr_last;
        wptr           <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule
